// File: rtl/imem_boot_loader_if.sv
// Host-side bundle of the instruction-memory boot loader: load control,
// the word stream handshake, the memory initialize port and status outputs.
interface imem_boot_loader_if;
    logic        start;
    logic [15:0] prog_len;
    logic [31:0] exp_sum;
    logic        abort;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        initialize;
    logic [31:0] instruction_initialize_address;
    logic [31:0] instruction_initialize_data;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    // The loader itself
    modport slave (
        input  start, prog_len, exp_sum, abort, in_valid, in_data,
        output in_ready, initialize, instruction_initialize_address,
               instruction_initialize_data, cpu_rst, busy, done, error,
               words_loaded
    );

    // The host / test driver
    modport master (
        output start, prog_len, exp_sum, abort, in_valid, in_data,
        input  in_ready, initialize, instruction_initialize_address,
               instruction_initialize_data, cpu_rst, busy, done, error,
               words_loaded
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot sequencer: streams a program into the CPU instruction memory, checks
// a running mod-2^32 checksum, then holds the CPU in reset for a fixed
// settle time before releasing it.
module imem_boot_loader #(
    parameter int DEPTH          = 64,
    parameter int RELEASE_CYCLES = 4
) (
    input logic               clk,
    input logic               rst,
    imem_boot_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RELEASE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] prog_len_q, prog_len_d;
    logic [31:0] exp_sum_q, exp_sum_d;
    logic [31:0] sum_q, sum_d;
    logic [15:0] words_q, words_d;
    logic [15:0] rel_cnt_q, rel_cnt_d;
    logic        init_q, init_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;

    logic        in_ready;
    logic        handshake;
    logic        len_ok;

    assign in_ready  = (state_q == S_LOAD) && !bus.abort;
    assign handshake = bus.in_valid && in_ready;
    assign len_ok    = (bus.prog_len != 16'd0) && (bus.prog_len <= 16'(DEPTH));

    // Next-state logic; the registered initialize strobe is a one-cycle
    // echo of each accepted word, addressed by its index before increment
    always_comb begin
        state_d    = state_q;
        prog_len_d = prog_len_q;
        exp_sum_d  = exp_sum_q;
        sum_d      = sum_q;
        words_d    = words_q;
        rel_cnt_d  = rel_cnt_q;
        init_d     = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (len_ok) begin
                        state_d    = S_LOAD;
                        prog_len_d = bus.prog_len;
                        exp_sum_d  = bus.exp_sum;
                        sum_d      = 32'd0;
                        words_d    = 16'd0;
                        rel_cnt_d  = 16'd0;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_LOAD: begin
                if (handshake) begin
                    sum_d   = sum_q + bus.in_data;
                    words_d = words_q + 16'd1;
                    init_d  = 1'b1;
                    addr_d  = {14'd0, words_q, 2'b00};
                    data_d  = bus.in_data;
                    if (words_q + 16'd1 == prog_len_q) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (sum_q == exp_sum_q) begin
                    state_d   = S_RELEASE;
                    rel_cnt_d = 16'd0;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_RELEASE: begin
                if (rel_cnt_q == 16'(RELEASE_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else begin
                    rel_cnt_d = rel_cnt_q + 16'd1;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything outside IDLE; in_ready is already low
        // so no word is taken, while a strobe registered last cycle finishes
        if (state_q != S_IDLE && bus.abort) begin
            state_d   = S_IDLE;
            sum_d     = 32'd0;
            words_d   = 16'd0;
            rel_cnt_d = 16'd0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prog_len_q <= 16'd0;
            exp_sum_q  <= 32'd0;
            sum_q      <= 32'd0;
            words_q    <= 16'd0;
            rel_cnt_q  <= 16'd0;
            init_q     <= 1'b0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            prog_len_q <= prog_len_d;
            exp_sum_q  <= exp_sum_d;
            sum_q      <= sum_d;
            words_q    <= words_d;
            rel_cnt_q  <= rel_cnt_d;
            init_q     <= init_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign bus.in_ready                       = in_ready;
    assign bus.initialize                     = init_q;
    assign bus.instruction_initialize_address = addr_q;
    assign bus.instruction_initialize_data    = data_q;
    assign bus.cpu_rst                        = (state_q != S_RUN);
    assign bus.busy                           = (state_q == S_LOAD) || (state_q == S_CHECK) ||
                                                (state_q == S_RELEASE);
    assign bus.done                           = (state_q == S_RUN);
    assign bus.error                          = (state_q == S_ERROR);
    assign bus.words_loaded                   = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: table of load scenarios, randomized loads
// judged by a word-list/checksum model, and hand-written abort/reset cases.
module tb_imem_boot_loader;

    localparam int DEPTH = 64;
    localparam int RC    = 4;

    logic clk = 1'b0;
    logic rst;

    imem_boot_loader_if bus();

    imem_boot_loader #(
        .DEPTH(DEPTH),
        .RELEASE_CYCLES(RC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] words[DEPTH+1];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];

    // Record every initialize strobe seen by the instruction memory
    always @(negedge clk) begin
        if (bus.initialize === 1'b1) begin
            obs_addr.push_back(bus.instruction_initialize_address);
            obs_data.push_back(bus.instruction_initialize_data);
        end
    end

    typedef struct {
        int  len;
        int  kind;
        int  sum_adj;
        int  gap_max;
        bit  exp_done;
        bit  exp_err;
    } vec_t;

    vec_t tbl[9];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [15:0] len, input logic [31:0] sum,
                                 input logic ab, input logic v, input logic [31:0] d);
        bus.start    = s;
        bus.prog_len = len;
        bus.exp_sum  = sum;
        bus.abort    = ab;
        bus.in_valid = v;
        bus.in_data  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] modelSum(input int n);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < n && i <= DEPTH; i++) s = s + words[i];
        return s;
    endfunction

    function automatic bit modelLenOk(input int n);
        return (n >= 1) && (n <= DEPTH);
    endfunction

    task automatic fillWords(input int kind);
        for (int i = 0; i <= DEPTH; i++) begin
            if (kind == 1) words[i] = 32'(i + 1);
            else           words[i] = $urandom;
        end
        if (kind == 0) begin
            words[0] = 32'h20280005;
            words[1] = 32'h00220820;
            words[2] = 32'h00221822;
            words[3] = 32'h00222025;
            words[4] = 32'h3C051234;
            words[5] = 32'h08000007;
            words[6] = 32'h0022302A;
            words[7] = 32'h1422FFFF;
        end
    endtask

    task automatic abortToIdle(input string tag);
        applyStimulus(1'b0, 16'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        tick();
        applyStimulus(1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        checkOutput({tag, " abort busy"}, bus.busy, 0);
        checkOutput({tag, " abort error"}, bus.error, 0);
        checkOutput({tag, " abort done"}, bus.done, 0);
        checkOutput({tag, " abort cpu_rst"}, bus.cpu_rst, 1);
        checkOutput({tag, " abort words_loaded"}, bus.words_loaded, 0);
    endtask

    // One complete load; the run is over at RUN or ERROR.  In edge counts,
    // RUN follows the last handshake edge by 1+RC edges and a checksum
    // ERROR by one edge.
    task automatic runLoad(input string tag, input int len, input logic [31:0] sum,
                           input int gap_max, input bit exp_done, input bit exp_err);
        int hs_edge;
        int got_edge;
        int bad;
        bit finished;
        obs_addr.delete();
        obs_data.delete();
        applyStimulus(1'b1, len[15:0], sum, 1'b0, 1'b0, 32'd0);
        tick();
        applyStimulus(1'b0, len[15:0], sum, 1'b0, 1'b0, 32'd0);
        if (!modelLenOk(len)) begin
            checkOutput({tag, " bad-len error"}, bus.error, 1);
            checkOutput({tag, " bad-len busy"}, bus.busy, 0);
            tick();
            tick();
            checkOutput({tag, " bad-len pulses"}, obs_addr.size(), 0);
            checkOutput({tag, " bad-len cpu_rst"}, bus.cpu_rst, 1);
            return;
        end
        checkOutput({tag, " in_ready after start"}, bus.in_ready, 1);
        hs_edge = cyc;
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                applyStimulus(1'b0, len[15:0], sum, 1'b0, 1'b0, 32'd0);
                tick();
            end
            applyStimulus(1'b0, len[15:0], sum, 1'b0, 1'b1, words[i]);
            tick();
            hs_edge = cyc;
        end
        applyStimulus(1'b0, len[15:0], sum, 1'b0, 1'b0, 32'd0);
        checkOutput({tag, " words_loaded"}, bus.words_loaded, 32'(len));
        finished = 1'b0;
        got_edge = -1;
        for (int w = 0; w < 40 && !finished; w++) begin
            if (bus.done === 1'b1 || bus.error === 1'b1) begin
                finished = 1'b1;
                got_edge = cyc;
            end else begin
                tick();
            end
        end
        checkOutput({tag, " finished in time"}, 32'(finished), 1);
        checkOutput({tag, " done"}, bus.done, 32'(exp_done));
        checkOutput({tag, " error"}, bus.error, 32'(exp_err));
        checkOutput({tag, " cpu_rst"}, bus.cpu_rst, 32'(!exp_done));
        checkOutput({tag, " latency"}, 32'(got_edge - hs_edge), exp_done ? 32'(1 + RC) : 32'd1);
        checkOutput({tag, " pulse count"}, obs_addr.size(), 32'(len));
        bad = 0;
        for (int i = 0; i < obs_addr.size() && i < len; i++) begin
            if (obs_addr[i] !== 32'(4 * i) || obs_data[i] !== words[i]) bad++;
        end
        checkOutput({tag, " pulse content"}, 32'(bad), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tbl[0] = '{8,  0, 0,  0, 1'b1, 1'b0};
        tbl[1] = '{3,  1, 0,  5, 1'b1, 1'b0};
        tbl[2] = '{3,  1, 1,  0, 1'b0, 1'b1};
        tbl[3] = '{0,  1, 0,  0, 1'b0, 1'b1};
        tbl[4] = '{65, 1, 0,  0, 1'b0, 1'b1};
        tbl[5] = '{64, 2, 0,  1, 1'b1, 1'b0};
        tbl[6] = '{1,  2, 0,  3, 1'b1, 1'b0};
        tbl[7] = '{17, 2, -1, 2, 1'b0, 1'b1};
        tbl[8] = '{40, 2, 0,  0, 1'b1, 1'b0};

        rst = 1'b1;
        applyStimulus(1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        repeat (2) tick();
        checkOutput("reset cpu_rst", bus.cpu_rst, 1);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset done", bus.done, 0);
        checkOutput("reset error", bus.error, 0);
        checkOutput("reset initialize", bus.initialize, 0);
        checkOutput("reset in_ready", bus.in_ready, 0);
        checkOutput("reset words_loaded", bus.words_loaded, 0);
        checkOutput("reset address", bus.instruction_initialize_address, 0);
        checkOutput("reset data", bus.instruction_initialize_data, 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            fillWords(tbl[v].kind);
            runLoad($sformatf("tbl%0d", v), tbl[v].len,
                    modelSum(tbl[v].len) + 32'(tbl[v].sum_adj),
                    tbl[v].gap_max, tbl[v].exp_done, tbl[v].exp_err);
            abortToIdle($sformatf("tbl%0d", v));
        end

        for (int r = 0; r < 6; r++) begin
            int len;
            int adj;
            bit ok;
            len = $urandom_range(0, DEPTH + 2);
            adj = $urandom_range(0, 1);
            fillWords(2);
            ok = modelLenOk(len) && (adj == 0);
            runLoad($sformatf("rnd%0d", r), len, modelSum(len) + 32'(adj), 3, ok, !ok);
            abortToIdle($sformatf("rnd%0d", r));
        end

        // Abort while the 4th word is offered: only 3 words are written
        fillWords(0);
        obs_addr.delete();
        obs_data.delete();
        applyStimulus(1'b1, 16'd8, modelSum(8), 1'b0, 1'b0, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'd8, modelSum(8), 1'b0, 1'b1, words[i]);
            tick();
        end
        applyStimulus(1'b0, 16'd8, modelSum(8), 1'b1, 1'b1, words[3]);
        #1;
        checkOutput("abort-cycle in_ready", bus.in_ready, 0);
        tick();
        applyStimulus(1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("mid-load abort busy", bus.busy, 0);
        checkOutput("mid-load abort words_loaded", bus.words_loaded, 0);
        tick();
        checkOutput("mid-load abort pulse count", obs_addr.size(), 3);
        checkOutput("mid-load abort last address", obs_addr[obs_addr.size() - 1], 32'd8);
        checkOutput("mid-load abort last data", obs_data[obs_data.size() - 1], words[2]);
        runLoad("reload", 8, modelSum(8), 0, 1'b1, 1'b0);
        abortToIdle("reload");

        // Asynchronous reset in the middle of RELEASE
        fillWords(1);
        applyStimulus(1'b1, 16'd3, 32'd6, 1'b0, 1'b0, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'd3, 32'd6, 1'b0, 1'b1, words[i]);
            tick();
        end
        applyStimulus(1'b0, 16'd3, 32'd6, 1'b0, 1'b0, 32'd0);
        repeat (3) tick();
        checkOutput("in release busy", bus.busy, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst cpu_rst", bus.cpu_rst, 1);
        checkOutput("async rst done", bus.done, 0);
        checkOutput("async rst busy", bus.busy, 0);
        checkOutput("async rst words_loaded", bus.words_loaded, 0);
        checkOutput("async rst address", bus.instruction_initialize_address, 0);
        #1;
        rst = 1'b0;
        repeat (3) tick();
        checkOutput("post-rst idle busy", bus.busy, 0);
        checkOutput("post-rst idle done", bus.done, 0);

        // Abort alone in IDLE does nothing; start together with abort wins
        applyStimulus(1'b0, 16'd3, 32'd6, 1'b1, 1'b0, 32'd0);
        tick();
        checkOutput("idle abort busy", bus.busy, 0);
        checkOutput("idle abort error", bus.error, 0);
        applyStimulus(1'b1, 16'd3, 32'd6, 1'b1, 1'b0, 32'd0);
        tick();
        applyStimulus(1'b0, 16'd3, 32'd6, 1'b0, 1'b0, 32'd0);
        checkOutput("start beats abort busy", bus.busy, 1);
        abortToIdle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
